sl_transmitter: RTL and testbench

SL_TRANSMITTER -- requirements
Module: sl_transmitter

---
 rtl/sl_transmitter.sv | 233 +++++++++++++++++++++++
 tb/tb_sl_transmitter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sl_transmitter.sv
// sl_transmitter: serialises a configurable-length word onto a two-wire SL link
// (zeroes/ones lines, idle high), followed by a parity symbol and a stop symbol.
module sl_transmitter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] wr_config_w,
    input  logic        wr_enable,
    input  logic [31:0] data_w,
    input  logic        send,
    output logic        serial_line_zeroes,
    output logic        serial_line_ones,
    output logic [15:0] r_config_w,
    output logic        busy,
    output logic        done,
    output logic [15:0] status_w
);

    localparam int unsigned CFG_W   = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TMR_W   = 6;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned LEN_W   = 6;
    localparam int unsigned RATE_W  = 2;

    // Only parity_inject, word_len and rate are stored; reserved bits read as 0.
    localparam logic [CFG_W-1:0] CFG_MASK  = 16'h01FF;
    localparam logic [CFG_W-1:0] CFG_RESET = 16'h0010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BIT_PRE,
        S_BIT_PULSE,
        S_BIT_POST,
        S_PAR_PRE,
        S_PAR,
        S_GAP,
        S_STOP,
        S_STOP_POST
    } state_e;

    state_e              state_q,   state_d;
    logic [TMR_W-1:0]    timer_q,   timer_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic [RATE_W-1:0]   rate_q,    rate_d;
    logic                inj_q,     inj_d;
    logic                par_q,     par_d;
    logic [CFG_W-1:0]    cfg_q,     cfg_d;
    logic                err_q,     err_d;
    logic                drop_q,    drop_d;
    logic                zero_q,    zero_d;
    logic                one_q,     one_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic [LEN_W-1:0]    wr_len;
    logic                wr_legal;
    logic [TMR_W-1:0]    unit_last;
    logic [TMR_W-1:0]    half_last;
    logic                half_state;
    logic                timer_end;
    logic [CNT_W-1:0]    bit_cnt_inc;

    // Decode the incoming config word and check word_len legality (even, 8..32).
    always_comb begin
        wr_len   = wr_config_w[6:1];
        wr_legal = (wr_len[0] == 1'b0) && (wr_len >= LEN_W'(8)) && (wr_len <= LEN_W'(32));
    end

    // Last timer value for a full unit L and a half unit H at the latched rate.
    always_comb begin
        unit_last = TMR_W'(7);
        half_last = TMR_W'(3);
        case (rate_q)
            2'd0: begin unit_last = TMR_W'(7);  half_last = TMR_W'(3);  end
            2'd1: begin unit_last = TMR_W'(15); half_last = TMR_W'(7);  end
            2'd2: begin unit_last = TMR_W'(31); half_last = TMR_W'(15); end
            default: begin unit_last = TMR_W'(63); half_last = TMR_W'(31); end
        endcase
    end

    // Half-unit states end at H-1, all others at L-1.
    always_comb begin
        half_state  = (state_q == S_BIT_PRE) || (state_q == S_BIT_POST) ||
                      (state_q == S_PAR_PRE) || (state_q == S_STOP_POST);
        timer_end   = half_state ? (timer_q == half_last) : (timer_q == unit_last);
        bit_cnt_inc = CNT_W'(bit_cnt_q + CNT_W'(1));
    end

    // Next-state, frame datapath and status logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        len_d     = len_q;
        rate_d    = rate_q;
        inj_d     = inj_q;
        par_d     = par_q;
        cfg_d     = cfg_q;
        err_d     = err_q;
        drop_d    = drop_q;
        done_d    = 1'b0;

        if (wr_enable) begin
            drop_d = 1'b0;
            if (wr_legal) begin
                cfg_d = wr_config_w & CFG_MASK;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_q == S_IDLE) begin
            if (send) begin
                if (err_q) begin
                    drop_d = 1'b1;
                end else begin
                    state_d   = S_BIT_PRE;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    shreg_d   = data_w;
                    len_d     = cfg_q[6:1];
                    rate_d    = cfg_q[8:7];
                    inj_d     = cfg_q[0];
                    par_d     = 1'b0;
                end
            end
        end else begin
            if (send) begin
                drop_d = 1'b1;
            end
            if (!timer_end) begin
                timer_d = TMR_W'(timer_q + TMR_W'(1));
            end else begin
                timer_d = '0;
                case (state_q)
                    S_BIT_PRE:   state_d = S_BIT_PULSE;
                    S_BIT_PULSE: state_d = S_BIT_POST;
                    S_BIT_POST: begin
                        par_d     = par_q ^ shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_inc;
                        state_d   = (bit_cnt_inc == CNT_W'(len_q)) ? S_PAR_PRE : S_BIT_PRE;
                    end
                    S_PAR_PRE:   state_d = S_PAR;
                    S_PAR:       state_d = S_GAP;
                    S_GAP:       state_d = S_STOP;
                    S_STOP:      state_d = S_STOP_POST;
                    S_STOP_POST: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default:     state_d = S_IDLE;
                endcase
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Line levels follow the current state; word_len is even, so the zero-count
    // parity equals the one-count parity accumulated in par_q.
    always_comb begin
        zero_d = 1'b1;
        one_d  = 1'b1;
        case (state_q)
            S_BIT_PULSE: begin
                if (shreg_q[0]) one_d  = 1'b0;
                else            zero_d = 1'b0;
            end
            S_PAR: begin
                zero_d = ~par_q ^ inj_q;
                one_d  = par_q ^ inj_q;
            end
            S_STOP: begin
                zero_d = 1'b0;
                one_d  = 1'b0;
            end
            default: begin
                zero_d = 1'b1;
                one_d  = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            len_q     <= LEN_W'(8);
            rate_q    <= '0;
            inj_q     <= 1'b0;
            par_q     <= 1'b0;
            cfg_q     <= CFG_RESET;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            zero_q    <= 1'b1;
            one_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            len_q     <= len_d;
            rate_q    <= rate_d;
            inj_q     <= inj_d;
            par_q     <= par_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            zero_q    <= zero_d;
            one_q     <= one_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign serial_line_zeroes = zero_q;
    assign serial_line_ones   = one_q;
    assign r_config_w         = cfg_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign status_w           = {14'b0, drop_q, err_q};

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed scoreboard bench for sl_transmitter: each accepted send pushes the
// expected per-cycle {zeroes, ones, busy, done} trace, popped every cycle.
module tb_sl_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wr_config_w;
    logic        wr_enable;
    logic [31:0] data_w;
    logic        send;
    logic        serial_line_zeroes;
    logic        serial_line_ones;
    logic [15:0] r_config_w;
    logic        busy;
    logic        done;
    logic [15:0] status_w;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    sl_transmitter dut (
        .clk                (clk),
        .rst                (rst),
        .wr_config_w        (wr_config_w),
        .wr_enable          (wr_enable),
        .data_w             (data_w),
        .send               (send),
        .serial_line_zeroes (serial_line_zeroes),
        .serial_line_ones   (serial_line_ones),
        .r_config_w         (r_config_w),
        .busy               (busy),
        .done               (done),
        .status_w           (status_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample #1 after the edge and compare against the scoreboard head.
    task automatic cycle();
        logic [3:0] e;
        @(posedge clk);
        #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b1100;
        check_eq("line_busy_done", 32'({serial_line_zeroes, serial_line_ones, busy, done}), 32'(e));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Build the expected frame: state timeline t=0..F-1, lines lag state by one cycle.
    task automatic push_frame(input logic [31:0] data, input int wl, input int rate, input logic inj);
        logic [1:0] tl[$];
        int         l, h, ones, f;
        logic       b, pz, po;
        l = 8 << rate;
        h = l / 2;
        ones = 0;
        for (int i = 0; i < wl; i++) begin
            b = data[i];
            if (b) ones++;
            for (int c = 0; c < h; c++) tl.push_back(2'b11);
            for (int c = 0; c < l; c++) tl.push_back(b ? 2'b10 : 2'b01);
            for (int c = 0; c < h; c++) tl.push_back(2'b11);
        end
        pz = 1'b1 ^ 1'((wl - ones) % 2) ^ inj;
        po = 1'((ones % 2)) ^ inj;
        for (int c = 0; c < h; c++) tl.push_back(2'b11);
        for (int c = 0; c < l; c++) tl.push_back({pz, po});
        for (int c = 0; c < l; c++) tl.push_back(2'b11);
        for (int c = 0; c < l; c++) tl.push_back(2'b00);
        for (int c = 0; c < h; c++) tl.push_back(2'b11);
        f = tl.size();
        exp_q.push_back(4'b1110);
        for (int j = 1; j < f; j++) exp_q.push_back({tl[j-1], 2'b10});
        exp_q.push_back({tl[f-1], 2'b01});
    endtask

    // Run until the scoreboard drains; afterwards the bench sits in the done cycle.
    task automatic wait_frame();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            cycle();
            n++;
        end
        check_eq("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start(input logic [31:0] d, input int wl, input int rate, input logic inj);
        data_w = d;
        send   = 1'b1;
        push_frame(d, wl, rate, inj);
        cycle();
        send   = 1'b0;
    endtask

    task automatic write_cfg(input logic [15:0] w);
        wr_config_w = w;
        wr_enable   = 1'b1;
        cycle();
        wr_enable   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_config_w = '0; wr_enable = 1'b0; data_w = '0; send = 1'b0;
        @(posedge clk);
        #1;
        run(2);
        rst = 1'b0;
        check_eq("reset_config", 32'(r_config_w), 32'h0010);
        check_eq("reset_status", 32'(status_w), 32'h0000);
        run(3);

        // Default config frame, then a back-to-back frame sent in the done cycle.
        start(32'h0000_00A5, 8, 0, 1'b0);
        wait_frame();
        start(32'h0000_003C, 8, 0, 1'b0);
        wait_frame();
        run(2);

        // Send while busy is dropped; a config write clears the flag.
        start(32'h0000_0096, 8, 0, 1'b0);
        run(20);
        send = 1'b1;
        cycle();
        send = 1'b0;
        check_eq("drop_sticky", 32'(status_w), 32'h0002);
        run(5);
        check_eq("drop_held", 32'(status_w), 32'h0002);
        write_cfg(16'h0010);
        check_eq("drop_cleared", 32'(status_w), 32'h0000);
        wait_frame();
        run(2);

        // Parity inject with reserved bits set in the write.
        write_cfg(16'hFE11);
        check_eq("cfg_reserved_zero", 32'(r_config_w), 32'h0011);
        start(32'h0000_0001, 8, 0, 1'b1);
        wait_frame();
        run(2);

        // Illegal word_len: error set, config kept, later send dropped.
        write_cfg(16'h0012);
        check_eq("cfg_err_set", 32'(status_w), 32'h0001);
        check_eq("cfg_unchanged", 32'(r_config_w), 32'h0011);
        send = 1'b1;
        cycle();
        send = 1'b0;
        check_eq("send_dropped_err", 32'(status_w), 32'h0003);
        run(10);
        write_cfg(16'h0010);
        check_eq("cfg_err_clear", 32'(status_w), 32'h0000);
        check_eq("cfg_reloaded", 32'(r_config_w), 32'h0010);

        // Config write mid-frame applies to the next frame only.
        start(32'h0000_005A, 8, 0, 1'b0);
        run(30);
        write_cfg(16'h0095);
        check_eq("cfg_mid_frame", 32'(r_config_w), 32'h0095);
        wait_frame();
        start(32'h0000_02C3, 10, 1, 1'b1);
        wait_frame();
        run(2);

        // Longest frame: word_len 32 at the slowest rate.
        write_cfg(16'h01C0);
        check_eq("cfg_long", 32'(r_config_w), 32'h01C0);
        start(32'hFFFF_FFFF, 32, 3, 1'b0);
        wait_frame();
        run(2);

        // Reset during the pulse of bit 3 wins over simultaneous send and write.
        write_cfg(16'h0010);
        start(32'h0000_00B6, 8, 0, 1'b0);
        run(55);
        rst = 1'b1; send = 1'b1; wr_enable = 1'b1; wr_config_w = 16'h0095;
        exp_q.delete();
        cycle();
        rst = 1'b0; send = 1'b0; wr_enable = 1'b0;
        check_eq("rst_config", 32'(r_config_w), 32'h0010);
        check_eq("rst_status", 32'(status_w), 32'h0000);
        run(3);
        start(32'h0000_00B6, 8, 0, 1'b0);
        wait_frame();
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
